// File: rtl/fpu_writeback_regfile_if.sv
// Bundle of issue, read-port, FPU write-back and load-return signals for the
// floating-point register file.
interface fpu_writeback_regfile_if;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [4:0]  rd_a_addr;
    logic [4:0]  rd_b_addr;
    logic [31:0] rd_a_data;
    logic [31:0] rd_b_data;
    logic        fpu_enable;
    logic [4:0]  fpu_addr;
    logic [31:0] fpu_data;
    logic        fpu_float;
    logic        mem_enable;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        stall;

    modport master (
        output issue_valid, issue_addr, rd_a_addr, rd_b_addr,
        output fpu_enable, fpu_addr, fpu_data, fpu_float,
        output mem_enable, mem_addr, mem_data,
        input  rd_a_data, rd_b_data, mem_ready, stall
    );

    modport slave (
        input  issue_valid, issue_addr, rd_a_addr, rd_b_addr,
        input  fpu_enable, fpu_addr, fpu_data, fpu_float,
        input  mem_enable, mem_addr, mem_data,
        output rd_a_data, rd_b_data, mem_ready, stall
    );
endinterface

// File: rtl/fpu_writeback_regfile.sv
// Floating-point register file with FPU/load write arbitration, a small load
// overflow FIFO, latency-0 read forwarding and a per-register RAW scoreboard.
module fpu_writeback_regfile #(
    parameter int NREG      = 32,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    fpu_writeback_regfile_if.slave  bus
);
    localparam int BCW = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]      regs_val [NREG];
    logic [CNT_W-1:0] cnt_val  [NREG];

    logic [BCW-1:0] buf_cnt_q, buf_cnt_d;
    logic [4:0]     buf_addr_q [BUF_DEPTH];
    logic [4:0]     buf_addr_d [BUF_DEPTH];
    logic [31:0]    buf_data_q [BUF_DEPTH];
    logic [31:0]    buf_data_d [BUF_DEPTH];

    logic        fpu_wr, mem_acc, buf_empty, buf_drain, mem_enq;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    assign bus.mem_ready = (buf_cnt_q < BCW'(BUF_DEPTH));
    assign fpu_wr    = bus.fpu_enable & bus.fpu_float;
    assign mem_acc   = bus.mem_enable & bus.mem_ready;
    assign buf_empty = (buf_cnt_q == '0);
    assign buf_drain = !fpu_wr && !buf_empty;
    // A load goes straight to the array only when nothing older is queued.
    assign mem_enq   = mem_acc && (fpu_wr || !buf_empty);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (fpu_wr) begin
            wr_en   = 1'b1;
            wr_addr = bus.fpu_addr;
            wr_data = bus.fpu_data;
        end else if (buf_drain) begin
            wr_en   = 1'b1;
            wr_addr = buf_addr_q[0];
            wr_data = buf_data_q[0];
        end else if (mem_acc) begin
            wr_en   = 1'b1;
            wr_addr = bus.mem_addr;
            wr_data = bus.mem_data;
        end
    end

    // FIFO kept compacted: entry 0 is always the oldest.
    always_comb begin
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        buf_cnt_d  = buf_cnt_q;
        if (buf_drain) begin
            for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                buf_addr_d[i] = buf_addr_q[i+1];
                buf_data_d[i] = buf_data_q[i+1];
            end
            buf_cnt_d = buf_cnt_q - BCW'(1);
        end
        if (mem_enq) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (BCW'(i) == buf_cnt_d) begin
                    buf_addr_d[i] = bus.mem_addr;
                    buf_data_d[i] = bus.mem_data;
                end
            end
            buf_cnt_d = buf_cnt_d + BCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_cnt_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_addr_q[i] <= '0;
                buf_data_q[i] <= '0;
            end
        end else begin
            buf_cnt_q  <= buf_cnt_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            logic [31:0]      val_q;
            logic [CNT_W-1:0] cnt_q;
            logic             inc, dec;

            assign inc = bus.issue_valid && (bus.issue_addr == 5'(gi));
            assign dec = fpu_wr && (bus.fpu_addr == 5'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    val_q <= '0;
                end else if (wr_en && (wr_addr == 5'(gi))) begin
                    val_q <= wr_data;
                end
            end

            // Write-backs after a reset may find the counter already at 0.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (inc && !dec && (cnt_q != CNT_MAX)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end else if (dec && !inc && (cnt_q != '0)) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end

            assign regs_val[gi] = val_q;
            assign cnt_val[gi]  = cnt_q;
        end
    endgenerate

    logic [4:0]  rd_addr [2];
    logic [31:0] rd_data [2];

    assign rd_addr[0]    = bus.rd_a_addr;
    assign rd_addr[1]    = bus.rd_b_addr;
    assign bus.rd_a_data = rd_data[0];
    assign bus.rd_b_data = rd_data[1];

    // Later assignments override earlier ones, so the youngest value wins.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                rd_data[gi] = regs_val[rd_addr[gi]];
                for (int i = 0; i < BUF_DEPTH; i++) begin
                    if ((BCW'(i) < buf_cnt_q) && (buf_addr_q[i] == rd_addr[gi])) begin
                        rd_data[gi] = buf_data_q[i];
                    end
                end
                if (mem_acc && (bus.mem_addr == rd_addr[gi])) begin
                    rd_data[gi] = bus.mem_data;
                end
                if (fpu_wr && (bus.fpu_addr == rd_addr[gi])) begin
                    rd_data[gi] = bus.fpu_data;
                end
            end
        end
    endgenerate

    assign bus.stall = (cnt_val[bus.rd_a_addr] != '0)
                     | (cnt_val[bus.rd_b_addr] != '0)
                     | (cnt_val[bus.issue_addr] == CNT_MAX);

endmodule

// File: tb/tb_fpu_writeback_regfile.sv
// Vector-table bench for fpu_writeback_regfile: each row drives one cycle of
// stimulus and its expected outputs travel through a scoreboard queue.
module tb_fpu_writeback_regfile;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fpu_writeback_regfile_if bus_if ();

    fpu_writeback_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        string       name;
        logic        r;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        fe;
        logic        ff;
        logic [4:0]  fa;
        logic [31:0] fd;
        logic        me;
        logic [4:0]  ma;
        logic [31:0] md;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        es;
        logic        er;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        es;
        logic        er;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input string n, input logic r, input logic iv,
                                input logic [4:0] ia, input logic [4:0] ra, input logic [4:0] rb,
                                input logic fe, input logic ff, input logic [4:0] fa,
                                input logic [31:0] fd, input logic me, input logic [4:0] ma,
                                input logic [31:0] md, input logic [31:0] ea, input logic [31:0] eb,
                                input logic es, input logic er);
        vec_t v;
        v.name = n; v.r = r; v.iv = iv; v.ia = ia; v.ra = ra; v.rb = rb;
        v.fe = fe; v.ff = ff; v.fa = fa; v.fd = fd;
        v.me = me; v.ma = ma; v.md = md;
        v.ea = ea; v.eb = eb; v.es = es; v.er = er;
        return v;
    endfunction

    task automatic check(input string n, input string what,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", n, what, act, req);
        end
    endtask

    task automatic drive_idle();
        bus_if.issue_valid = 1'b0; bus_if.issue_addr = '0;
        bus_if.rd_a_addr   = '0;   bus_if.rd_b_addr  = '0;
        bus_if.fpu_enable  = 1'b0; bus_if.fpu_addr   = '0;
        bus_if.fpu_data    = '0;   bus_if.fpu_float  = 1'b0;
        bus_if.mem_enable  = 1'b0; bus_if.mem_addr   = '0;
        bus_if.mem_data    = '0;
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst                = v.r;
        bus_if.issue_valid = v.iv; bus_if.issue_addr = v.ia;
        bus_if.rd_a_addr   = v.ra; bus_if.rd_b_addr  = v.rb;
        bus_if.fpu_enable  = v.fe; bus_if.fpu_float  = v.ff;
        bus_if.fpu_addr    = v.fa; bus_if.fpu_data   = v.fd;
        bus_if.mem_enable  = v.me; bus_if.mem_addr   = v.ma;
        bus_if.mem_data    = v.md;
        sb.push_back('{v.name, v.ea, v.eb, v.es, v.er});
        #2;
        e = sb.pop_front();
        $display("txn %-14s ra=%0d rb=%0d a=%h b=%h stall=%b rdy=%b",
                 e.name, v.ra, v.rb, bus_if.rd_a_data, bus_if.rd_b_data,
                 bus_if.stall, bus_if.mem_ready);
        check(e.name, "rd_a",  bus_if.rd_a_data, e.ea);
        check(e.name, "rd_b",  bus_if.rd_b_data, e.eb);
        check(e.name, "stall", {31'd0, bus_if.stall}, {31'd0, e.es});
        check(e.name, "rdy",   {31'd0, bus_if.mem_ready}, {31'd0, e.er});
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);

        // Table: name, rst, iv, ia, ra, rb, fe, ff, fa, fd, me, ma, md, exp_a, exp_b, exp_stall, exp_rdy
        // RAW hazard on f5 across the 3-cycle FPU latency
        vecs.push_back(mk("iss_f5",      0,1,5, 0, 0, 0,1, 0,32'h0,        0, 0,32'h0,        32'h0,        32'h0,        0,1));
        vecs.push_back(mk("haz_f5_1",    0,0,0, 5, 0, 0,1, 0,32'h0,        0, 0,32'h0,        32'h0,        32'h0,        1,1));
        vecs.push_back(mk("haz_f5_2",    0,0,0, 5, 0, 0,1, 0,32'h0,        0, 0,32'h0,        32'h0,        32'h0,        1,1));
        vecs.push_back(mk("wb_f5",       0,0,0, 5, 0, 1,1, 5,32'h3F800000, 0, 0,32'h0,        32'h3F800000, 32'h0,        1,1));
        vecs.push_back(mk("rel_f5",      0,0,0, 5, 0, 0,1, 0,32'h0,        0, 0,32'h0,        32'h3F800000, 32'h0,        0,1));
        // FPU and load in the same cycle; load is buffered then drains
        vecs.push_back(mk("fpu_mem",     0,0,0, 3, 2, 1,1, 2,32'h40000000, 1, 3,32'h40400000, 32'h40400000, 32'h40000000, 0,1));
        vecs.push_back(mk("buf_bypass",  0,0,0, 3, 2, 0,1, 0,32'h0,        0, 0,32'h0,        32'h40400000, 32'h40000000, 0,1));
        vecs.push_back(mk("drained_f3",  0,0,0, 3, 5, 0,1, 0,32'h0,        0, 0,32'h0,        32'h40400000, 32'h3F800000, 0,1));
        // Four back-to-back FPU+load cycles: buffer fills, later loads dropped
        vecs.push_back(mk("burst1",      0,0,0,10,20, 1,1,10,32'h41200000, 1,20,32'h41A00000, 32'h41200000, 32'h41A00000, 0,1));
        vecs.push_back(mk("burst2",      0,0,0,11,21, 1,1,11,32'h41300000, 1,21,32'h41A80000, 32'h41300000, 32'h41A80000, 0,1));
        vecs.push_back(mk("burst3",      0,0,0,12,22, 1,1,12,32'h41400000, 1,22,32'h41B00000, 32'h41400000, 32'h0,        0,0));
        vecs.push_back(mk("burst4",      0,0,0,13,23, 1,1,13,32'h41500000, 1,23,32'h41B80000, 32'h41500000, 32'h0,        0,0));
        vecs.push_back(mk("drain1",      0,0,0,20,21, 0,1, 0,32'h0,        0, 0,32'h0,        32'h41A00000, 32'h41A80000, 0,0));
        vecs.push_back(mk("drain2",      0,0,0,20,21, 0,1, 0,32'h0,        0, 0,32'h0,        32'h41A00000, 32'h41A80000, 0,1));
        vecs.push_back(mk("drain3",      0,0,0,21,22, 0,1, 0,32'h0,        0, 0,32'h0,        32'h41A80000, 32'h0,        0,1));
        vecs.push_back(mk("burst_final", 0,0,0,10,13, 0,1, 0,32'h0,        0, 0,32'h0,        32'h41200000, 32'h41500000, 0,1));
        // Two buffered loads to the same register must retire in FIFO order
        vecs.push_back(mk("fifo_ord1",   0,0,0,24,14, 1,1,14,32'h11111111, 1,24,32'hAAAA0001, 32'hAAAA0001, 32'h11111111, 0,1));
        vecs.push_back(mk("fifo_ord2",   0,0,0,24,15, 1,1,15,32'h22222222, 1,24,32'hAAAA0002, 32'hAAAA0002, 32'h22222222, 0,1));
        vecs.push_back(mk("fifo_ord3",   0,0,0,24,14, 0,1, 0,32'h0,        0, 0,32'h0,        32'hAAAA0002, 32'h11111111, 0,0));
        vecs.push_back(mk("fifo_ord4",   0,0,0,24,15, 0,1, 0,32'h0,        0, 0,32'h0,        32'hAAAA0002, 32'h22222222, 0,1));
        vecs.push_back(mk("fifo_ord5",   0,0,0,24, 0, 0,1, 0,32'h0,        0, 0,32'h0,        32'hAAAA0002, 32'h0,        0,1));
        // Counter saturation at 3 on f7, then three write-backs
        vecs.push_back(mk("iss_f7_1",    0,1,7, 0, 0, 0,1, 0,32'h0,        0, 0,32'h0,        32'h0,        32'h0,        0,1));
        vecs.push_back(mk("iss_f7_2",    0,1,7, 0, 0, 0,1, 0,32'h0,        0, 0,32'h0,        32'h0,        32'h0,        0,1));
        vecs.push_back(mk("iss_f7_3",    0,1,7, 0, 0, 0,1, 0,32'h0,        0, 0,32'h0,        32'h0,        32'h0,        0,1));
        vecs.push_back(mk("wb_f7_full",  0,0,7, 0, 0, 1,1, 7,32'h40A00000, 0, 0,32'h0,        32'h0,        32'h0,        1,1));
        vecs.push_back(mk("wb_f7_2",     0,0,7, 0, 0, 1,1, 7,32'h40C00000, 0, 0,32'h0,        32'h0,        32'h0,        0,1));
        vecs.push_back(mk("wb_f7_3",     0,0,7, 7, 0, 1,1, 7,32'h40E00000, 0, 0,32'h0,        32'h40E00000, 32'h0,        1,1));
        vecs.push_back(mk("f7_final",    0,0,7, 7, 0, 0,1, 0,32'h0,        0, 0,32'h0,        32'h40E00000, 32'h0,        0,1));
        // fpu_float=0 write is ignored
        vecs.push_back(mk("float0",      0,0,0, 9, 0, 1,0, 9,32'hDEADBEEF, 0, 0,32'h0,        32'h0,        32'h0,        0,1));
        vecs.push_back(mk("float0_chk",  0,0,0, 9, 0, 0,1, 0,32'h0,        0, 0,32'h0,        32'h0,        32'h0,        0,1));
        // Same-cycle issue and write-back on f8 leaves the count unchanged
        vecs.push_back(mk("iss_f8",      0,1,8, 0, 0, 0,1, 0,32'h0,        0, 0,32'h0,        32'h0,        32'h0,        0,1));
        vecs.push_back(mk("iss_wb_f8",   0,1,8, 0, 0, 1,1, 8,32'h3F000000, 0, 0,32'h0,        32'h0,        32'h0,        0,1));
        vecs.push_back(mk("wb_f8",       0,0,0, 8, 0, 1,1, 8,32'h3E800000, 0, 0,32'h0,        32'h3E800000, 32'h0,        1,1));
        vecs.push_back(mk("f8_clear",    0,0,0, 8, 0, 0,1, 0,32'h0,        0, 0,32'h0,        32'h3E800000, 32'h0,        0,1));
        // Reset with cnt[4]=2 and one buffered load, then a late write-back to f4
        vecs.push_back(mk("iss_f4_1",    0,1,4, 0, 0, 0,1, 0,32'h0,        0, 0,32'h0,        32'h0,        32'h0,        0,1));
        vecs.push_back(mk("iss_f4_2",    0,1,4,16,17, 1,1,16,32'h00000001, 1,17,32'h00000002, 32'h00000001, 32'h00000002, 0,1));
        vecs.push_back(mk("rst_pulse",   1,0,0, 0, 0, 0,1, 0,32'h0,        0, 0,32'h0,        32'h0,        32'h0,        0,1));
        vecs.push_back(mk("post_rst",    0,0,4,16,17, 0,1, 0,32'h0,        0, 0,32'h0,        32'h0,        32'h0,        0,1));
        vecs.push_back(mk("post_rst_f4", 0,0,0, 4, 0, 0,1, 0,32'h0,        0, 0,32'h0,        32'h0,        32'h0,        0,1));
        vecs.push_back(mk("late_wb_f4",  0,0,4, 0, 0, 1,1, 4,32'h7F800000, 0, 0,32'h0,        32'h0,        32'h0,        0,1));
        vecs.push_back(mk("late_wb_chk", 0,0,4, 4, 0, 0,1, 0,32'h0,        0, 0,32'h0,        32'h7F800000, 32'h0,        0,1));

        // Post-reset sweep of all registers
        for (int i = 0; i < 32; i++) begin
            apply(mk("reset_rd", 0, 0, 5'(i), 5'(i), 5'(31 - i), 0, 1, 0, 32'h0,
                     0, 0, 32'h0, 32'h0, 32'h0, 0, 1));
        end

        foreach (vecs[k]) begin
            apply(vecs[k]);
        end

        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_writeback_regfile.md
Name: fpu_writeback_regfile

Overview:
- Receiving end of the FPU result write-back interface (enable/addr/data/float), plus the FPU load-return path.
- Holds the 32x32-bit floating-point register file and supplies the rs/rt operands to the FPU issue stage.
- Tracks in-flight FPU destinations in a scoreboard and raises a RAW-hazard stall for decode.
- Arbitrates same-cycle FPU and memory writes through a small overflow buffer.

Parameters:
- NREG, 32, number of float registers (address width fixed at 5).
- BUF_DEPTH, 2, memory-write overflow buffer entries.
- CNT_W, 2, width of each per-register pending counter. Maximum in-flight count is 3, matching the 3-cycle FPU pipeline.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- issue_valid  in  1  an FPU op is issued this cycle; it will write issue_addr.
- issue_addr  in  5  destination of the issued op.
- rd_a_addr  in  5  read port A address (rs).
- rd_b_addr  in  5  read port B address (rt).
- rd_a_data  out  32  port A data.
- rd_b_data  out  32  port B data.
- fpu_enable  in  1  FPU write-back valid.
- fpu_addr  in  5  FPU write-back register.
- fpu_data  in  32  FPU write-back data.
- fpu_float  in  1  write targets the float file; the write is ignored when this is 0.
- mem_enable  in  1  load-return write valid.
- mem_addr  in  5  load-return register.
- mem_data  in  32  load-return data.
- mem_ready  out  1  buffer can accept a mem write this cycle.
- stall  out  1  decode must hold; issue_valid must be 0 while stall=1.

Behaviour:
- Reset:
  - All registers, pending counters and buffer entries cleared; buffer count = 0.
  - stall=0, mem_ready=1, rd_*_data=0.
  - Reset mid-operation discards all in-flight bookkeeping; FPU results arriving after reset still write the array but do not decrement counters below 0.
- Write arbitration, each posedge:
  - FPU write (fpu_enable & fpu_float) has priority and writes the array directly.
  - A mem write with no FPU write and an empty buffer writes the array directly.
  - Otherwise the mem write is appended to the FIFO buffer.
  - When there is no FPU write, the oldest buffer entry drains to the array. Any new mem write that cycle is enqueued behind it, preserving order.
  - mem_ready = (buffer count < BUF_DEPTH). A mem_enable while mem_ready=0 is a protocol error and the write is dropped.
- Read ports (combinational, youngest value wins):
  - Priority order: current-cycle FPU write, then current-cycle mem write, then buffer entries newest to oldest, then the array.
  - This makes results visible at latency 0.
- Scoreboard:
  - cnt[r] increments on issue_valid to r.
  - cnt[r] decrements on a valid FPU write to r.
  - Simultaneous increment and decrement on the same r leaves cnt unchanged.
  - A decrement at 0 saturates at 0.
- stall = (cnt[rd_a_addr]!=0) | (cnt[rd_b_addr]!=0) | (cnt[issue_addr]==3), evaluated on the current-cycle counters.
  - A write-back arriving in the same cycle does not release the stall; stall releases the following cycle.
- Write ordering: results from the fixed-latency FPU retire in issue order, so no WAW check is needed.
  - A mem write to a register with cnt!=0 is allowed; the later FPU write overwrites it.

Test Plan:
- Reset, then read f0..f31 -> all rd data 0, stall=0, mem_ready=1.
- issue_valid to f5; three cycles later fpu_enable addr=5 data=0x3F800000 float=1:
  - stall=1 while rd_a_addr=5 during the 3 cycles in between.
  - rd_a_data=0x3F800000 in the write-back cycle.
  - stall=0 the next cycle.
- Same cycle: fpu write f2=0x40000000 and mem write f3=0x40400000:
  - f2 is written; f3 is buffered, and a read of f3 bypasses the buffer giving 0x40400000.
  - f3 drains to the array on the next idle cycle.
- Four consecutive cycles of fpu+mem writes:
  - mem_ready=0 after two buffered entries.
  - Entries drain in FIFO order once FPU writes stop; final values are checked.
- Three back-to-back issues to f7 -> cnt=3 and stall=1 while issue_addr=7. Three write-backs bring cnt back to 0 and the final value equals the third result.
- Assert rst with cnt[4]=2 and one buffered entry -> all state clears next cycle. A late FPU write to f4 updates the array and cnt stays 0.
